// File: rtl/shift_reg.sv
// Serial-in, parallel-out shift register with registered status outputs.
// Shifts one bit per clock into q[0]. The oldest bit appears on sout.
// Alongside the data it tracks a saturating fill count and a population count.
module shift_reg #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             databit,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CW-1:0]    ones,
  output logic             full,
  output logic [CW-1:0]    fill,
  output logic             all_zero,
  output logic             all_one
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    ones_q, ones_d;
  logic [CW-1:0]    fill_q, fill_d;

  // Next-state: shift in databit, update popcount incrementally, saturate fill
  always_comb begin
    data_d = {data_q[WIDTH-2:0], databit};
    // The bit leaving at the top is exactly the one dropped from the count, so
    // the count tracks the new register contents without a full popcount.
    ones_d = ones_q + CW'(databit) - CW'(data_q[WIDTH-1]);
    fill_d = fill_q;
    if (fill_q != CW'(WIDTH)) begin
      fill_d = fill_q + CW'(1);
    end
  end

  // State registers; active-low asynchronous clear discards contents and fill
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      ones_q <= '0;
      fill_q <= '0;
    end else begin
      data_q <= data_d;
      ones_q <= ones_d;
      fill_q <= fill_d;
    end
  end

  // Outputs derive directly from registered state
  always_comb begin
    q        = data_q;
    sout     = data_q[WIDTH-1];
    ones     = ones_q;
    fill     = fill_q;
    full     = (fill_q == CW'(WIDTH));
    all_zero = (ones_q == '0);
    all_one  = (ones_q == CW'(WIDTH));
  end

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg: directed scenarios plus random stream
// compared against a history-queue reference model.
module tb_shift_reg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             databit = 1'b0;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic [CW-1:0]    ones;
  logic             full;
  logic [CW-1:0]    fill;
  logic             all_zero;
  logic             all_one;

  shift_reg #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .databit  (databit),
    .q        (q),
    .sout     (sout),
    .ones     (ones),
    .full     (full),
    .fill     (fill),
    .all_zero (all_zero),
    .all_one  (all_one)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference: bits captured since reset, newest first, at most WIDTH kept.
  bit hist[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mdl_q();
    logic [63:0] v;
    v = '0;
    foreach (hist[i]) v[i] = hist[i];
    return v;
  endfunction

  task automatic check_all(input string tag);
    logic [63:0] mq;
    int unsigned pc;
    mq = mdl_q();
    pc = $countones(mq);
    chk({tag, ".q"},        64'(q),        mq);
    chk({tag, ".sout"},     64'(sout),     64'(mq[WIDTH-1]));
    chk({tag, ".ones"},     64'(ones),     64'(pc));
    chk({tag, ".fill"},     64'(fill),     64'(hist.size()));
    chk({tag, ".full"},     64'(full),     64'(hist.size() == WIDTH));
    chk({tag, ".all_zero"}, 64'(all_zero), 64'(pc == 0));
    chk({tag, ".all_one"},  64'(all_one),  64'(pc == WIDTH));
  endtask

  task automatic step(input logic b);
    databit = b;
    @(posedge clk);
    if (rst) begin
      hist.push_front(b);
      if (hist.size() > WIDTH) void'(hist.pop_back());
    end
    #1;
    check_all("step");
  endtask

  // Called shortly after a rising edge; reset lands between edges.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    hist.delete();
    #1;
    check_all("arst");
    @(negedge clk);
    check_all("arst_hold");
    rst = 1'b1;
  endtask

  initial begin
    logic [63:0] e;
    logic [7:0]  pat;

    // Reset held with clock running and databit high
    rst = 1'b0;
    databit = 1'b1;
    #1;
    check_all("reset");
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      chk("reset_q", 64'(q), 64'd0);
      chk("reset_az", 64'(all_zero), 64'd1);
    end
    @(negedge clk);
    rst = 1'b1;

    // Single pulse walks to sout
    step(1'b1);
    chk("pulse_q0", 64'(q), 64'd1);
    chk("pulse_fill", 64'(fill), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0);
      e = (k < 8) ? (64'd1 << k) : 64'd0;
      chk("pulse_q", 64'(q), e);
      chk("pulse_sout", 64'(sout), 64'(k == 7));
    end
    chk("pulse_ones", 64'(ones), 64'd0);

    // Two pulses six cycles apart
    step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);
    step(1'b1);
    chk("two_q", 64'(q), 64'h41);
    chk("two_ones", 64'(ones), 64'd2);

    // Fill from a fresh reset
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    #1;
    check_all("fill_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1);
      chk("fill_cnt", 64'(fill), 64'((i < 8) ? i : 8));
      chk("fill_full", 64'(full), 64'(i >= 8));
    end
    chk("fill_q", 64'(q), 64'hFF);
    chk("fill_all_one", 64'(all_one), 64'd1);
    chk("fill_ones", 64'(ones), 64'd8);

    // Enter/exit balance, then drain
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      chk("bal_ones", 64'(ones), 64'd8);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0);
      chk("drain_ones", 64'(ones), 64'(8 - i));
    end
    chk("drain_az", 64'(all_zero), 64'd1);

    // Asynchronous reset mid-stream with q = 0xA5
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) step(pat[i]);
    chk("mid_q", 64'(q), 64'hA5);
    chk("mid_full", 64'(full), 64'd1);
    async_reset();
    chk("mid_rst_q", 64'(q), 64'd0);
    chk("mid_rst_full", 64'(full), 64'd0);
    step(1'b1);
    chk("mid_refill", 64'(fill), 64'd1);

    // Random stream with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) async_reset();
      step(1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
